// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor.
// Computes diff = a - b one bit per clock, LSB first, using a single
// full-subtractor cell and a borrow flip-flop. A start/busy/done handshake
// drives it. A result takes WIDTH shift edges and is presented with a
// one-cycle done pulse. diff/borrow/overflow hold until the next result.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_overflow;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_d_sr_next;
  logic             w_ovf;

  // Full-subtractor cell on the current LSBs plus the stored borrow.
  assign w_d       = r_a_sr[0] ^ r_b_sr[0] ^ r_br;
  assign w_br_next = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_br);

  // The new difference bit enters at the MSB so the result ends up aligned
  // after WIDTH shifts. A one-bit datapath has nothing to shift in from above.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign w_d_sr_next = w_d;
    end else begin : g_wide
      assign w_d_sr_next = {w_d, r_d_sr[WIDTH-1:1]};
    end
  endgenerate

  // Signed overflow: operands of differing sign whose result sign differs from the minuend.
  assign w_ovf = (r_a_msb != r_b_msb) && (w_d_sr_next[WIDTH-1] != r_a_msb);

  // Control FSM, shift datapath and the result registers, all in one clocked process.
  // NOTE: every register here uses <= so that all of them sample the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift registers are cleared too, even though the datapath reloads them on start. Their reset values are therefore deterministic.
      r_state    <= S_IDLE;
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_d_sr     <= '0;
      r_br       <= 1'b0;
      r_cnt      <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_diff     <= '0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_d_sr <= w_d_sr_next;
          r_br   <= w_br_next;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            r_diff     <= w_d_sr_next;
            r_borrow   <= w_br_next;
            r_overflow <= w_ovf;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign diff     = r_diff;
  assign borrow   = r_borrow;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor.
// It uses a WIDTH=16 instance for the main handshake and arithmetic cases,
// and a WIDTH=1 instance for the half-subtractor corner.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;

  logic        start16;
  logic [15:0] a16, b16;
  logic        busy16, done16, borrow16, ovf16;
  logic [15:0] diff16;

  logic        start1;
  logic [0:0]  a1, b1;
  logic        busy1, done1, borrow1, ovf1;
  logic [0:0]  diff1;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
  } vec16_t;

  typedef struct {
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
  } res16_t;

  typedef struct {
    logic a;
    logic b;
    logic diff;
    logic borrow;
    logic ovf;
  } vec1_t;

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16), .overflow(ovf16)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands.
  function automatic res16_t model16(input logic [15:0] ta, input logic [15:0] tb);
    res16_t r;
    int sa, sb, sd;
    r.diff   = ta - tb;
    r.borrow = (ta < tb);
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    sd = sa - sb;
    r.ovf = (sd > 32767) || (sd < -32768);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait for done16 from the negedge after the accepting edge; returns edges and busy cycles.
  task automatic wait_done16(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done16 && lat < 40) begin
      if (busy16) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (busy16) busy_cnt++;
  endtask

  task automatic op16(input string name, input logic [15:0] ta, input logic [15:0] tb,
                      input logic [15:0] ed, input logic eb, input logic eo);
    int lat, bc;
    @(negedge clk);
    a16 = ta; b16 = tb; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    wait_done16(lat, bc);
    check({name, " latency"}, lat, 16);
    check({name, " busy_cycles"}, bc, 17);
    check({name, " diff"}, diff16, ed);
    check({name, " borrow"}, borrow16, eb);
    check({name, " overflow"}, ovf16, eo);
    @(negedge clk);
    check({name, " done_pulse_end"}, {busy16, done16}, 2'b00);
    check({name, " diff_hold"}, diff16, ed);
  endtask

  task automatic op1(input string name, input vec1_t v);
    int lat;
    @(negedge clk);
    a1 = v.a; b1 = v.b; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~v.a; b1 = ~v.b;
    lat = 0;
    while (!done1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, 1);
    check({name, " diff"}, diff1, v.diff);
    check({name, " borrow"}, borrow1, v.borrow);
    check({name, " overflow"}, ovf1, v.ovf);
    @(negedge clk);
    check({name, " done_end"}, {busy1, done1}, 2'b00);
  endtask

  initial begin
    vec16_t tab16[6];
    vec1_t  tab1[4];
    res16_t m;
    int lat, bc, pulses;

    tab16[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
    tab16[1] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
    tab16[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    tab16[3] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
    tab16[4] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tab16[5] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1};

    tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tab1[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tab1[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tab1[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    check("reset16", {busy16, done16, diff16, borrow16, ovf16}, 20'h0);
    check("reset1", {busy1, done1, diff1, borrow1, ovf1}, 5'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy16, done16}, 2'b00);

    // Directed arithmetic table, including the signed/unsigned boundary cases.
    foreach (tab16[i])
      op16($sformatf("tab%0d", i), tab16[i].a, tab16[i].b, tab16[i].diff,
           tab16[i].borrow, tab16[i].ovf);

    // start held high; operands change while busy; back-to-back accept after done.
    @(negedge clk);
    a16 = 16'd5; b16 = 16'd3; start16 = 1'b1;
    @(negedge clk);
    a16 = 16'd9; b16 = 16'd1;
    wait_done16(lat, bc);
    check("held_start latency", lat, 16);
    check("held_start diff1", diff16, 16'h0002);
    @(negedge clk);
    check("held_start idle_gap", {busy16, done16}, 2'b00);
    @(negedge clk);
    start16 = 1'b0;
    check("held_start reaccepted", busy16, 1'b1);
    wait_done16(lat, bc);
    check("held_start latency2", lat, 16);
    check("held_start diff2", diff16, 16'h0008);
    @(negedge clk);
    check("held_start single_done", {busy16, done16}, 2'b00);

    // Reset in mid-SHIFT aborts the operation with no done pulse.
    @(negedge clk);
    a16 = 16'h00FF; b16 = 16'h0001; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_abort busy", {busy16, done16}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort state", {busy16, done16, diff16, borrow16, ovf16}, 20'h0);
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done16 || busy16) pulses++;
    end
    check("abort no_done", pulses, 0);
    op16("after_abort", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);

    // Randomised operands against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 5 == 0) rb = ra;
      m = model16(ra, rb);
      op16($sformatf("rand%0d", i), ra, rb, m.diff, m.borrow, m.ovf);
    end

    // WIDTH=1 degenerate half-subtractor.
    foreach (tab1[i])
      op1($sformatf("w1_%0d", i), tab1[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
